// File: rtl/expr_lane_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : expr_lane_pkg
//  Description : Shared opcode encoding and saturation-limit helpers for the
//                expr_lane_pipe datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package expr_lane_pkg;

  localparam int OP_W  = 3;
  localparam int MAX_W = 16;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_GE  = 3'd5,
    OP_SHR = 3'd6,
    OP_ACC = 3'd7
  } op_e;

  // Largest representable value of a w-bit lane (low w bits are meaningful).
  function automatic logic [MAX_W-1:0] sat_max_val(input int w, input bit sgn);
    return sgn ? ((16'd1 << (w - 1)) - 16'd1) : ((16'd1 << w) - 16'd1);
  endfunction

  // Smallest representable value of a w-bit lane (low w bits are meaningful).
  function automatic logic [MAX_W-1:0] sat_min_val(input int w, input bit sgn);
    return sgn ? (16'd1 << (w - 1)) : 16'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/expr_lane_pipe_alu.sv
`default_nettype none
// ============================================================================
//  Module      : expr_lane_alu
//  Description : Combinational single-lane datapath. Signedness is fixed by
//                the SIGNED parameter. Optional saturation of ADD/SUB/ACC is
//                enabled by defining EXPR_LANE_PIPE_SAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module expr_lane_alu
  import expr_lane_pkg::*;
#(
  parameter int W      = 6,
  parameter bit SIGNED = 1'b0
) (
  input  op_e          op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] acc,
  output logic [W-1:0] res,
  output logic         ovf
);

  localparam int SH_W = $clog2(W);

  // ACC reuses the adder with the accumulator as the first operand.
  logic [W-1:0]    add_x;
  logic [W-1:0]    add_y;
  logic [W:0]      sum;
  logic [W:0]      diff;
  logic [SH_W-1:0] sh;
  logic            add_ovf;
  logic            sub_ovf;
  logic            ge;
  logic [W-1:0]    shr;

  assign add_x = (op == OP_ACC) ? acc : a;
  assign add_y = (op == OP_ACC) ? a : b;
  assign sum   = {1'b0, add_x} + {1'b0, add_y};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign sh    = b[SH_W-1:0];

  if (SIGNED) begin : g_signed
    // Overflow when like-signed operands produce a result of the other sign.
    assign add_ovf = (add_x[W-1] == add_y[W-1]) && (sum[W-1] != add_x[W-1]);
    assign sub_ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
    assign ge      = ($signed(a) >= $signed(b));
    assign shr     = $signed(a) >>> sh;
  end else begin : g_unsigned
    // Carry out of the adder, borrow out of the subtractor.
    assign add_ovf = sum[W];
    assign sub_ovf = diff[W];
    assign ge      = (a >= b);
    assign shr     = a >> sh;
  end

`ifdef EXPR_LANE_PIPE_SAT_EN
  localparam logic [MAX_W-1:0] SAT_MAX_F = sat_max_val(W, SIGNED);
  localparam logic [MAX_W-1:0] SAT_MIN_F = sat_min_val(W, SIGNED);
  localparam logic [W-1:0]     SAT_MAX   = SAT_MAX_F[W-1:0];
  localparam logic [W-1:0]     SAT_MIN   = SAT_MIN_F[W-1:0];

  // Signed overflow direction follows the first operand's sign; unsigned
  // addition can only overflow upward and subtraction only downward.
  logic [W-1:0] add_sat;
  logic [W-1:0] sub_sat;
  assign add_sat = (SIGNED && add_x[W-1]) ? SAT_MIN : SAT_MAX;
  assign sub_sat = SIGNED ? (a[W-1] ? SAT_MIN : SAT_MAX) : SAT_MIN;
`endif

  // Opcode result selection; overflow only reported for the additive ops.
  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (op)
      OP_ADD, OP_ACC: begin
        res = sum[W-1:0];
        ovf = add_ovf;
`ifdef EXPR_LANE_PIPE_SAT_EN
        if (add_ovf) res = add_sat;
`endif
      end
      OP_SUB: begin
        res = diff[W-1:0];
        ovf = sub_ovf;
`ifdef EXPR_LANE_PIPE_SAT_EN
        if (sub_ovf) res = sub_sat;
`endif
      end
      OP_MUL:  res = a * b;
      OP_AND:  res = a & b;
      OP_XOR:  res = a ^ b;
      OP_GE:   res = {{(W-1){1'b0}}, ge};
      OP_SHR:  res = shr;
      default: res = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/expr_lane_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : expr_lane_pipe
//  Description : Two-stage valid/ready pipeline evaluating one opcode across
//                LANES operand pairs, with per-lane accumulators and overflow
//                flags. Saturating mode: define EXPR_LANE_PIPE_SAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module expr_lane_pipe
  import expr_lane_pkg::*;
#(
  parameter int               LANES       = 6,
  parameter int               W           = 6,
  parameter logic [LANES-1:0] SIGNED_MASK = 6'b111000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    in_op,
  input  logic [LANES*W-1:0] in_a,
  input  logic [LANES*W-1:0] in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_y,
  output logic [LANES-1:0]   out_ovf,
  output logic               out_par
);

  logic               advance;
  logic               s1_valid;
  op_e                s1_op;
  logic [LANES*W-1:0] s1_a;
  logic [LANES*W-1:0] s1_b;
  logic [LANES*W-1:0] res_all;
  logic [LANES-1:0]   ovf_all;

  // The whole pipe moves together whenever the output slot is free or drained.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Stage 1: capture the accepted transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_ADD;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op <= op_e'(in_op);
        s1_a  <= in_a;
        s1_b  <= in_b;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [W-1:0] acc;

    expr_lane_alu #(
      .W      (W),
      .SIGNED (SIGNED_MASK[i])
    ) u_alu (
      .op  (s1_op),
      .a   (s1_a[i*W +: W]),
      .b   (s1_b[i*W +: W]),
      .acc (acc),
      .res (res_all[i*W +: W]),
      .ovf (ovf_all[i])
    );

    // Accumulator commits alongside stage 2, so a following ACC sees it at once.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc <= '0;
      end else if (advance && s1_valid && (s1_op == OP_ACC)) begin
        acc <= res_all[i*W +: W];
      end
    end
  end

  // Stage 2: register lane results, overflow flags and parity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_ovf   <= '0;
      out_par   <= 1'b0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_y   <= res_all;
        out_ovf <= ovf_all;
        out_par <= ^res_all;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_expr_lane_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_expr_lane_pipe
//  Description : Scoreboard bench for expr_lane_pipe: directed vectors with
//                hand-computed results plus a randomised model-checked run.
//                Honours EXPR_LANE_PIPE_SAT_EN for saturating expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_expr_lane_pipe;
  import expr_lane_pkg::*;

  localparam int         LANES = 6;
  localparam int         W     = 6;
  localparam logic [5:0] MASK  = 6'b111000;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [35:0] in_a;
  logic [35:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [35:0] out_y;
  logic [5:0]  out_ovf;
  logic        out_par;

  expr_lane_pipe #(
    .LANES       (LANES),
    .W           (W),
    .SIGNED_MASK (MASK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_ovf   (out_ovf),
    .out_par   (out_par)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // out_ready is either a directed level or a random per-cycle value.
  logic ready_val = 1'b1;
  logic rnd_ready = 1'b0;
  logic rnd_bit   = 1'b1;
  assign out_ready = rnd_ready ? rnd_bit : ready_val;
  initial forever begin
    @(posedge clk);
    #1;
    rnd_bit = ($urandom_range(3) != 0);
  end

  typedef struct {
    logic [35:0] y;
    logic [5:0]  ovf;
    int          acc_cyc;
    bit          lat;
  } exp_t;

  exp_t        sbq[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [5:0]  m_acc[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
  endtask

  function automatic logic [35:0] pk(input int l5, l4, l3, l2, l1, l0);
    return {l5[5:0], l4[5:0], l3[5:0], l2[5:0], l1[5:0], l0[5:0]};
  endfunction

  function automatic logic [35:0] rep(input int v);
    return pk(v, v, v, v, v, v);
  endfunction

  // Reference model on integers; updates the model accumulators for ACC.
  function automatic void model(input logic [2:0] op, input logic [35:0] a, b,
                                output logic [35:0] y, output logic [5:0] ovf);
    y   = '0;
    ovf = '0;
    for (int i = 0; i < 6; i++) begin
      logic [5:0] aa, bb;
      logic [2:0] sh;
      int av, bv, cv, ex, lo, hi, r;
      bit sg;
      aa = a[i*6 +: 6];
      bb = b[i*6 +: 6];
      sg = MASK[i];
      av = int'(aa); if (sg && aa[5]) av -= 64;
      bv = int'(bb); if (sg && bb[5]) bv -= 64;
      cv = int'(m_acc[i]); if (sg && m_acc[i][5]) cv -= 64;
      lo = sg ? -32 : 0;
      hi = sg ? 31 : 63;
      r  = 0;
      case (op)
        OP_ADD, OP_SUB, OP_ACC: begin
          ex = (op == OP_ADD) ? av + bv : (op == OP_SUB) ? av - bv : cv + av;
          r  = ex;
          ovf[i] = (ex < lo) || (ex > hi);
`ifdef EXPR_LANE_PIPE_SAT_EN
          if (ex > hi) r = hi;
          else if (ex < lo) r = lo;
`endif
        end
        OP_MUL: r = av * bv;
        OP_AND: r = int'(aa & bb);
        OP_XOR: r = int'(aa ^ bb);
        OP_GE:  r = (av >= bv) ? 1 : 0;
        default: begin
          sh = bb[2:0];
          if (sg) r = (sh >= 3'd6) ? ((av < 0) ? -1 : 0) : (av >>> sh);
          else    r = av >> sh;
        end
      endcase
      y[i*6 +: 6] = r[5:0];
      if (op == OP_ACC) m_acc[i] = r[5:0];
    end
  endfunction

  // Monitor: pop and compare on every handshake; check stability while stalled.
  exp_t        mon_e;
  logic [35:0] held_y;
  bit          held = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("stall_out_y_stable", out_y, held_y);
        check("stall_out_valid_held", out_valid, 1);
        held = 1'b0;
      end
      if (out_valid && !out_ready) begin
        held   = 1'b1;
        held_y = out_y;
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: got y=%0h with empty scoreboard", out_y);
        end else begin
          mon_e = sbq.pop_front();
          check("out_y", out_y, mon_e.y);
          check("out_ovf", out_ovf, mon_e.ovf);
          check("out_par", out_par, ^mon_e.y);
          if (mon_e.lat) check("latency", cyc - mon_e.acc_cyc, 2);
        end
      end
    end
  end

  // Present one transaction and hold it until accepted (bounded).
  task automatic send(input logic [2:0] op, input logic [35:0] a, b,
                      input bit directed, input logic [35:0] ey,
                      input logic [5:0] eovf, input bit lat);
    logic [35:0] my;
    logic [5:0]  mo;
    exp_t        e;
    int          budget;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    budget   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        model(op, a, b, my, mo);
        e.y       = directed ? ey : my;
        e.ovf     = directed ? eovf : mo;
        e.acc_cyc = cyc;
        e.lat     = lat;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        break;
      end
      budget++;
      if (budget > 200) begin
        n_checks++;
        $display("FAIL send_timeout: in_ready low for %0d cycles", budget);
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int budget;
    in_valid = 1'b0;
    budget   = 0;
    while (sbq.size() != 0 && budget < 500) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (sbq.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d expected results never appeared", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic reset_pulse();
    in_valid = 1'b0;
    rst      = 1'b1;
    sbq.delete();
    for (int i = 0; i < 6; i++) m_acc[i] = '0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_y", out_y, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_out_par", out_par, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_op    = '0;
    in_a     = '0;
    in_b     = '0;
    for (int i = 0; i < 6; i++) m_acc[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_pulse();
    idle(1);

    // ADD: signed/unsigned wrap and overflow.
`ifdef EXPR_LANE_PIPE_SAT_EN
    send(OP_ADD, pk(31, 63, 10, 40, 10, 63), pk(1, 63, 5, 30, 20, 1), 1,
         pk(31, 62, 15, 63, 30, 63), 6'b100101, 1);
`else
    send(OP_ADD, pk(31, 63, 10, 40, 10, 63), pk(1, 63, 5, 30, 20, 1), 1,
         pk(32, 62, 15, 6, 30, 0), 6'b100101, 1);
`endif
    // SUB: borrow and signed overflow in both directions.
`ifdef EXPR_LANE_PIPE_SAT_EN
    send(OP_SUB, pk(32, 3, 31, 5, 10, 0), pk(1, 5, 63, 5, 3, 1), 1,
         pk(32, 62, 31, 0, 7, 0), 6'b101001, 1);
`else
    send(OP_SUB, pk(32, 3, 31, 5, 10, 0), pk(1, 5, 63, 5, 3, 1), 1,
         pk(31, 62, 32, 0, 7, 63), 6'b101001, 1);
`endif
    // GE, SHR, MUL, AND, XOR.
    send(OP_GE, pk(2, 0, 63, 0, 5, 2), pk(63, 63, 0, 1, 5, 63), 1,
         pk(1, 1, 0, 0, 1, 0), 6'b000000, 1);
    send(OP_SHR, pk(32, 32, 20, 63, 32, 32), pk(2, 7, 6, 9, 7, 2), 1,
         pk(56, 63, 0, 31, 0, 8), 6'b000000, 1);
    send(OP_MUL, pk(63, 0, 0, 0, 8, 7), pk(63, 0, 0, 0, 8, 9), 1,
         pk(1, 0, 0, 0, 0, 63), 6'b000000, 1);
    send(OP_AND, rep(42), rep(15), 1, rep(10), 6'b000000, 1);
    send(OP_XOR, rep(42), rep(15), 1, rep(37), 6'b000000, 1);
    drain();

    // Back-to-back ACC chain, then restart after reset.
    send(OP_ACC, rep(5), rep(0), 1, rep(5), 6'b000000, 1);
    send(OP_ACC, rep(5), rep(63), 1, rep(10), 6'b000000, 1);
    send(OP_ACC, rep(5), rep(0), 1, rep(15), 6'b000000, 1);
    drain();
    reset_pulse();
    send(OP_ACC, rep(5), rep(0), 1, rep(5), 6'b000000, 1);
    drain();

    // Output stall with input held valid.
    ready_val = 1'b0;
    fork
      begin
        send(OP_ADD, rep(1), rep(2), 1, rep(3), 6'b000000, 0);
        send(OP_XOR, rep(7), rep(1), 1, rep(6), 6'b000000, 0);
        send(OP_AND, rep(12), rep(10), 1, rep(8), 6'b000000, 0);
        send(OP_GE, rep(4), rep(4), 1, rep(1), 6'b000000, 0);
      end
      begin
        repeat (3) @(negedge clk);
        check("stall_in_ready_low", in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        ready_val = 1'b1;
      end
    join
    drain();

    // Reset while stalled drops in-flight work; restart at full latency.
    ready_val = 1'b0;
    send(OP_ADD, rep(9), rep(9), 1, rep(18), 6'b000000, 0);
    send(OP_ADD, rep(1), rep(1), 1, rep(2), 6'b000000, 0);
    idle(1);
    reset_pulse();
    @(negedge clk);
    check("post_rst_no_output", out_valid, 0);
    @(posedge clk);
    #1;
    ready_val = 1'b1;
    send(OP_ACC, rep(5), rep(0), 1, rep(5), 6'b000000, 1);
    drain();

    // Randomised run against the model with random valid/ready.
    rnd_ready = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      logic [63:0] ra, rb;
      if ($urandom_range(3) == 0) idle(1);
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      send(3'($urandom_range(7)), ra[35:0], rb[35:0], 0, '0, '0, 0);
    end
    drain();
    rnd_ready = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
